// File: rtl/updown_mod_counter.sv
// updown_mod_counter: bounded up/down counter 0..MAX
// with wrap or saturate limit modes and parallel load.
module updown_mod_counter #(
  parameter int BITS    = 8,
  parameter int RST_VAL = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            load,
  input  logic            up,
  input  logic            sat,
  input  logic [BITS-1:0] PI,
  input  logic [BITS-1:0] MAX,
  output logic [BITS-1:0] Q,
  output logic            tc,
  output logic            wrap
);

  localparam logic [BITS-1:0] RST_Q = BITS'(RST_VAL);
  localparam logic [BITS-1:0] ONE   = BITS'(1);
  localparam logic [BITS-1:0] ZERO  = '0;

  logic            at_top;
  logic            at_bot;
  logic            over;
  logic [BITS-1:0] ld_val;
  logic [BITS-1:0] q_nxt;
  logic            wrap_nxt;

  assign at_top = (Q >= MAX);
  assign at_bot = (Q == ZERO);
  assign over   = (Q > MAX);
  assign ld_val = (PI > MAX) ? MAX : PI;

  assign tc = en & ((up & at_top) | (~up & at_bot));

  // next count and wrap event: load > count > hold
  always_comb begin
    q_nxt    = Q;
    wrap_nxt = 1'b0;
    if (load) begin
      q_nxt = ld_val;
    end else if (en) begin
      if (up) begin
        if (!at_top) begin
          q_nxt = Q + ONE;
        end else if (sat) begin
          q_nxt = MAX;
        end else begin
          q_nxt    = ZERO;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (over) begin
          q_nxt = MAX;
        end else if (!at_bot) begin
          q_nxt = Q - ONE;
        end else if (!sat) begin
          q_nxt    = MAX;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  // count and wrap-pulse registers, sync reset wins
  always_ff @(posedge clk) begin
    if (rst) begin
      Q    <= RST_Q;
      wrap <= 1'b0;
    end else begin
      Q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule
